add_seq_ctrl: RTL and testbench
===============================

# add_seq_ctrl

Multi-byte addition sequencer that time-shares one 8-bit adder slice to add two WORDS-byte operands, least-significant byte first, chaining the carry through a register between slices. It sits between a requester with a valid/ready operand port and a consumer with a valid/ready result port. It replaces a wide carry chain with a single byte-wide adder at the cost of WORDS cycles per operation.

## Interface
- WORDS, default 4: operand width in bytes; legal range 2..16.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  8*WORDS  operand A.
- b  input  8*WORDS  operand B.
- cin  input  1  carry into byte 0.
- op  input  1  0 = add, 1 = subtract (A−B). Present only with ADD_SEQ_SUB_EN.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  8*WORDS  result.
- cout  output  1  carry out of the top byte.
- busy  output  1  high in RUN or HOLD.

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE: in_ready=1. When in_valid=1, on that edge:
  - latch a and b;
  - latch the effective cin (op and cin captured here);
  - set byte index idx=0;
  - go to RUN.
- RUN: each cycle:
  - slice computes {c, s} = a_byte[idx] + b_byte[idx] + carry_reg;
  - at the edge, s is written to sum byte idx, carry_reg <= c and idx++;
  - on the edge where idx==WORDS-1, go to HOLD and latch cout from c.
- HOLD: out_valid=1; sum and cout stay stable. When out_ready=1, go to IDLE at that edge.
- Width rules:
  - idx is clog2(WORDS) bits; it never wraps because the exit happens at WORDS-1.
  - All arithmetic is modulo 2^(8*WORDS); the carry out goes only to cout.
- Boundary cases:
  - in_valid while busy: ignored; in_ready=0, so no capture and no corruption of latched operands.
  - Input changes after acceptance have no effect.
  - out_ready high before HOLD: ignored.
  - out_ready and in_valid both high in HOLD: the result is retired and the new request is NOT accepted that cycle. It is accepted in the following IDLE cycle.
  - rst in any state: next state IDLE, idx=0, carry_reg=0. The in-flight operation is discarded and no out_valid is produced.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, sum=0, cout=0.
- Latency: out_valid rises exactly WORDS cycles after the accepting edge (edge where in_valid&in_ready=1).
- Throughput: minimum WORDS+2 cycles per operation, with out_ready held high.
- in_ready, out_valid and busy are decoded from registered state only; no combinational path from inputs to them.
- sum and cout change only in RUN and at reset.

## Configuration
- ADD_SEQ_SUB_EN defined:
  - op port exists.
  - With op=1, every B byte is inverted before the slice, and the carry latched at accept is 1 (cin is ignored).
  - Result is A−B mod 2^(8*WORDS); cout=1 means no borrow.
- ADD_SEQ_SUB_EN undefined:
  - no op port; addition only.
  - cin is always used as given.

## Structure
- Shared package add_pkg holds:
  - state enum typedef (IDLE, RUN, HOLD);
  - byte-width constant BYTE_W=8;
  - byte-select helper function.
- One sub-module: add_byte_slice, a combinational 8-bit adder with inputs a[7:0], b[7:0], cin and outputs s[7:0], c_out. It is instantiated once.
- The controller owns all registers: operand latches, sum, carry_reg, idx, state.

## Test plan (WORDS=4)
- Reset: hold rst high 2 cycles, then release → in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 → out_valid 4 cycles after accept, sum=0x00000000, cout=1.
- Backpressure: a=0x12345678, b=0x11111111, cin=1, out_ready low 5 cycles → sum=0x2345678A, cout=0, held stable. in_valid pulses during the hold are ignored and in_ready stays 0. Retired on the first out_ready.
- Reset mid-operation: assert rst 2 cycles after accepting a=0x000000FF, b=0x00000001 → IDLE next cycle and no out_valid. A following request a=1, b=2 yields sum=0x00000003.
- Back-to-back: two requests with out_ready tied high → accepts spaced exactly 6 cycles apart; results in order.
- ADD_SEQ_SUB_EN: op=1, a=0x00000005, b=0x00000007 → sum=0xFFFFFFFE, cout=0. Then a=7, b=5 → sum=0x00000002, cout=1.

Source files
------------

// File: rtl/add_pkg.sv
// add_pkg
// Shared definitions for the byte-serial addition sequencer.
//   state_t  : controller states (IDLE, RUN, HOLD)
//   BYTE_W   : width of one adder slice
//   byte_sel : picks byte 'idx' out of a vector of up to MAX_WORDS bytes
package add_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_WORDS = 16;
    localparam int MAX_BITS  = BYTE_W * MAX_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    // Callers zero-extend narrower operands to MAX_BITS so a single helper
    // serves every legal WORDS value.
    function automatic logic [BYTE_W-1:0] byte_sel(
        input logic [MAX_BITS-1:0] vec,
        input logic [3:0]          idx
    );
        return vec[idx*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/add_byte_slice.sv
// add_byte_slice
// Purely combinational 8-bit adder slice with carry in and carry out.
// Ports:
//   a, b  : byte operands
//   cin   : carry into the slice
//   s     : byte sum
//   c_out : carry out of the slice
module add_byte_slice
    import add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              c_out
);

    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl
// Adds two WORDS-byte operands one byte per cycle through a single shared
// add_byte_slice, least-significant byte first, carrying between bytes in
// carry_q. Result is held until the consumer accepts it.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   a, b, cin            : operands and carry into byte 0
//   op                   : 0 add, 1 subtract; exists only with ADD_SEQ_SUB_EN
//   out_valid / out_ready: result handshake (out_valid only in HOLD)
//   sum, cout            : result and carry out of the top byte
//   busy                 : high in RUN or HOLD
// Configuration macro: ADD_SEQ_SUB_EN enables the subtract mode and op port.
module add_seq_ctrl
    import add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W*WORDS-1:0] a,
    input  logic [BYTE_W*WORDS-1:0] b,
    input  logic                    cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                    op,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W*WORDS-1:0] sum,
    output logic                    cout,
    output logic                    busy
);

    localparam int DATA_W = BYTE_W * WORDS;
    localparam int IDX_W  = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   sum_q;
    logic                cout_q;
    logic                carry_q;
    logic [IDX_W-1:0]    idx_q;
`ifdef ADD_SEQ_SUB_EN
    logic                sub_q;
`endif

    logic                accept;
    logic                last_byte;
    logic                carry_in_eff;
    logic [MAX_BITS-1:0] a_ext;
    logic [MAX_BITS-1:0] b_ext;
    logic [3:0]          idx_ext;
    logic [BYTE_W-1:0]   slice_a;
    logic [BYTE_W-1:0]   slice_b;
    logic [BYTE_W-1:0]   slice_s;
    logic                slice_c;

    assign accept    = in_valid && (state_q == IDLE);
    assign last_byte = (idx_q == LAST_IDX);

    // Subtraction is A + ~B + 1, so the forced carry replaces cin.
`ifdef ADD_SEQ_SUB_EN
    assign carry_in_eff = op ? 1'b1 : cin;
`else
    assign carry_in_eff = cin;
`endif

    always_comb begin
        a_ext   = '0;
        b_ext   = '0;
        idx_ext = '0;
        a_ext[DATA_W-1:0] = a_q;
        b_ext[DATA_W-1:0] = b_q;
        idx_ext[IDX_W-1:0] = idx_q;
        slice_a = byte_sel(a_ext, idx_ext);
        slice_b = byte_sel(b_ext, idx_ext);
`ifdef ADD_SEQ_SUB_EN
        if (sub_q) begin
            slice_b = ~slice_b;
        end
`endif
    end

    add_byte_slice u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .s     (slice_s),
        .c_out (slice_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In HOLD a pending request is not looked at; it waits for IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_byte) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef ADD_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_in_eff;
            idx_q   <= '0;
`ifdef ADD_SEQ_SUB_EN
            sub_q   <= op;
`endif
        end else if (state_q == RUN) begin
            sum_q[idx_q*BYTE_W +: BYTE_W] <= slice_s;
            carry_q <= slice_c;
            // idx stops at the last byte so it can never wrap.
            if (last_byte) begin
                cout_q <= slice_c;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == RUN) || (state_q == HOLD);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl
// Directed testbench for add_seq_ctrl with WORDS=4. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_add_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef ADD_SEQ_SUB_EN
    logic         op;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int vectors;
    int miscompares;

    add_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SEQ_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one request, lets the DUT take it on the next rising edge,
    // then scrambles the inputs so a late capture would show up in the sum.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic opv);
        checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
`ifdef ADD_SEQ_SUB_EN
        op       = opv;
`else
        if (opv) $display("[TB] op ignored in add-only build");
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        cin      = ~cv;
`ifdef ADD_SEQ_SUB_EN
        op       = ~opv;
`endif
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
    endtask

    // Counts falling edges from the one just after the accepting edge until
    // out_valid; a correct DUT shows out_valid after exactly WORDS edges.
    task automatic waitValid(input string tag);
        int cycles;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, 64'(cycles), 64'(WORDS));
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput(tag, 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp_sum [2];
        logic         exp_cout [2];
        int           acc_cycle [2];
        int           accepts;
        int           results;
        int           seen_valid;

        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        op        = 1'b0;
`endif
        out_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_sum", 64'(sum), 64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);

        // Full carry ripple; out_ready raised during RUN must not retire early
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        out_ready = 1'b1;
        waitValid("ripple_latency");
        checkOutput("ripple_sum", 64'(sum), 64'h0000_0000);
        checkOutput("ripple_cout", 64'(cout), 64'd1);
        @(negedge clk);
        checkOutput("ripple_retired", 64'(out_valid), 64'd0);
        checkOutput("ripple_idle", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        // Backpressure with ignored requests during HOLD
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        waitValid("bp_latency");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 32'hDEAD_BEEF;
            b        = 32'h0BAD_F00D;
            @(negedge clk);
            checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_hold_sum", 64'(sum), 64'h2345_678A);
            checkOutput("bp_hold_cout", 64'(cout), 64'd0);
        end

        // out_ready and in_valid together in HOLD: retire only
        a         = 32'h0000_0001;
        b         = 32'h0000_0001;
        cin       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("both_retired", 64'(out_valid), 64'd0);
        checkOutput("both_not_accepted", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("both_next_accept", 64'(busy), 64'd1);
        waitValid("both_latency");
        checkOutput("both_sum", 64'(sum), 64'h0000_0002);
        checkOutput("both_cout", 64'(cout), 64'd0);
        retire("both_retire");

        // Reset two cycles into an operation
        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_sum", 64'(sum), 64'd0);
        out_ready  = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        checkOutput("midrst_no_valid", 64'(seen_valid), 64'd0);
        out_ready = 1'b0;
        applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        waitValid("midrst_latency");
        checkOutput("midrst_sum_after", 64'(sum), 64'h0000_0003);
        checkOutput("midrst_cout_after", 64'(cout), 64'd0);
        retire("midrst_retire");

        // Back-to-back with out_ready tied high
        exp_sum[0]  = 32'h0001_0000;
        exp_cout[0] = 1'b0;
        exp_sum[1]  = 32'h0000_0001;
        exp_cout[1] = 1'b1;
        accepts   = 0;
        results   = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 40 && results < 2; c++) begin
            if (accepts == 0) begin
                a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 1'b0;
            end else if (accepts == 1) begin
                a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                checkOutput("b2b_sum", 64'(sum), 64'(exp_sum[results]));
                checkOutput("b2b_cout", 64'(cout), 64'(exp_cout[results]));
                results++;
            end
            if (in_ready && in_valid && accepts < 2) begin
                acc_cycle[accepts] = c;
                accepts++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b_accepts", 64'(accepts), 64'd2);
        checkOutput("b2b_results", 64'(results), 64'd2);
        if (accepts == 2) begin
            checkOutput("b2b_spacing", 64'(acc_cycle[1] - acc_cycle[0]), 64'(WORDS + 2));
        end

`ifdef ADD_SEQ_SUB_EN
        // Subtract mode; cin is deliberately 0 to show it is ignored
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        waitValid("sub_latency_a");
        checkOutput("sub_sum_a", 64'(sum), 64'hFFFF_FFFE);
        checkOutput("sub_cout_a", 64'(cout), 64'd0);
        retire("sub_retire_a");
        applyStimulus(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        waitValid("sub_latency_b");
        checkOutput("sub_sum_b", 64'(sum), 64'h0000_0002);
        checkOutput("sub_cout_b", 64'(cout), 64'd1);
        retire("sub_retire_b");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
